// File: rtl/bsg_bladerunner_rom_banked_if.sv
// Endpoint-side request/response bundle for the banked configuration ROM server.
// The server takes the slave view; the network endpoint (or a bench) takes the master view.
interface bsg_bladerunner_rom_banked_if #(
  parameter int addr_width_p = 8,
  parameter int data_width_p = 32
) ();

  logic                        in_v_i;
  logic                        in_yumi_o;
  logic [addr_width_p-1:0]     in_addr_i;
  logic [data_width_p/8-1:0]   in_mask_i;
  logic                        in_we_i;
  logic                        returning_v_o;
  logic [data_width_p-1:0]     returning_data_o;
  logic                        returning_yumi_i;

  modport slave (
    input  in_v_i, in_addr_i, in_mask_i, in_we_i, returning_yumi_i,
    output in_yumi_o, returning_v_o, returning_data_o
  );

  modport master (
    output in_v_i, in_addr_i, in_mask_i, in_we_i, returning_yumi_i,
    input  in_yumi_o, returning_v_o, returning_data_o
  );

endinterface

// File: rtl/bsg_bladerunner_rom_banked.sv
// Read-only ROM server: wide entries split into link-width chunks, credit-reserved response FIFO.
// Optional saturating error counter enabled by defining BSG_BLADERUNNER_ROM_ERR_COUNT_EN.
module bsg_bladerunner_rom_banked #(
  parameter  int rom_width_p   = 64,
  parameter  int rom_els_p     = 6,
  parameter  int data_width_p  = 32,
  parameter  int addr_width_p  = 8,
  parameter  int fifo_els_p    = 4,
  localparam int chunks_lp     = (rom_width_p + data_width_p - 1) / data_width_p,
  localparam int lg_chunks_lp  = (chunks_lp == 1) ? 1 : $clog2(chunks_lp),
  localparam int lg_rom_els_lp = (rom_els_p == 1) ? 1 : $clog2(rom_els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bsg_bladerunner_rom_banked_if.slave  ep,
  output logic [lg_rom_els_lp-1:0]     rom_addr_o,
  input  logic [rom_width_p-1:0]       rom_data_i,
  output logic                         err_write_o,
  output logic                         err_oob_o,
  output logic [15:0]                  err_count_o
);

  localparam int mask_w_lp  = data_width_p / 8;
  localparam int pad_w_lp   = chunks_lp * data_width_p;
  localparam int lg_fifo_lp = $clog2(fifo_els_p);
  localparam int lg_cnt_lp  = $clog2(fifo_els_p + 1);

  function automatic logic [data_width_p-1:0] chunk_sel(
    input logic [pad_w_lp-1:0]     pad,
    input logic [lg_chunks_lp-1:0] c
  );
    logic [data_width_p-1:0] res;
    res = '0;
    for (int k = 0; k < chunks_lp; k++) begin
      if (int'(c) == k) res = pad[k*data_width_p +: data_width_p];
    end
    return res;
  endfunction

  function automatic logic [data_width_p-1:0] byte_mask(
    input logic [data_width_p-1:0] d,
    input logic [mask_w_lp-1:0]    m
  );
    logic [data_width_p-1:0] res;
    for (int b = 0; b < mask_w_lp; b++) begin
      res[8*b +: 8] = d[8*b +: 8] & {8{m[b]}};
    end
    return res;
  endfunction

  function automatic logic [lg_fifo_lp-1:0] ptr_next(input logic [lg_fifo_lp-1:0] p);
    return (int'(p) == fifo_els_p - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [lg_chunks_lp-1:0]  w_chunk;
  logic [lg_rom_els_lp-1:0] w_entry;
  logic                     w_oob;
  logic                     w_nonempty;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_credit_ok;
  logic                     w_yumi;
  logic                     w_acc_rd;
  logic                     w_acc_wr;

  logic                     r_vld_p1;
  logic [lg_rom_els_lp-1:0] r_entry_p1;
  logic [lg_chunks_lp-1:0]  r_chunk_p1;
  logic [mask_w_lp-1:0]     r_mask_p1;
  logic                     r_oob_p1;

  logic [pad_w_lp-1:0]      w_rom_pad;
  logic [data_width_p-1:0]  w_data_p2;

  logic [data_width_p-1:0]  r_mem [fifo_els_p];
  logic [lg_fifo_lp-1:0]    r_rd_ptr;
  logic [lg_fifo_lp-1:0]    r_wr_ptr;
  logic [lg_cnt_lp-1:0]     r_count;

  logic                     r_err_write;
  logic                     r_err_oob;

  generate
    if (chunks_lp == 1) begin : g_single_chunk
      assign w_chunk = '0;
      assign w_entry = ep.in_addr_i[lg_rom_els_lp-1:0];
    end else begin : g_multi_chunk
      assign w_chunk = ep.in_addr_i[lg_chunks_lp-1:0];
      assign w_entry = ep.in_addr_i[lg_chunks_lp +: lg_rom_els_lp];
    end
  endgenerate

  assign w_oob      = (int'(w_entry) >= rom_els_p);
  assign w_nonempty = (r_count != '0);
  assign w_pop      = ep.returning_yumi_i & w_nonempty;

  // A same-cycle pop frees its slot immediately, so it counts toward the credit.
  assign w_credit_ok = (int'(r_count) + int'(r_vld_p1)) < (fifo_els_p + int'(w_pop));
  assign w_yumi      = reset_n_i & ep.in_v_i & (ep.in_we_i | w_credit_ok);
  assign w_acc_rd    = w_yumi & ~ep.in_we_i;
  assign w_acc_wr    = w_yumi & ep.in_we_i;

  assign ep.in_yumi_o = w_yumi;

  // ---- stage 1: register accepted read ----
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_vld_p1   <= 1'b0;
      r_entry_p1 <= '0;
      r_chunk_p1 <= '0;
      r_mask_p1  <= '0;
      r_oob_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_acc_rd;
      if (w_acc_rd) begin
        r_entry_p1 <= w_entry;
        r_chunk_p1 <= w_chunk;
        r_mask_p1  <= ep.in_mask_i;
        r_oob_p1   <= w_oob;
      end
    end
  end

  assign rom_addr_o = r_entry_p1;

  // ---- stage 2: chunk select, byte mask, push to response FIFO ----
  always_comb begin
    w_rom_pad                    = '0;
    w_rom_pad[rom_width_p-1:0]   = rom_data_i;
  end

  assign w_data_p2 = r_oob_p1 ? '0 : byte_mask(chunk_sel(w_rom_pad, r_chunk_p1), r_mask_p1);
  assign w_push    = r_vld_p1;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_data_p2;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory contents are not reset, so the head is gated by occupancy.
  assign ep.returning_v_o    = w_nonempty;
  assign ep.returning_data_o = w_nonempty ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err_write <= 1'b0;
      r_err_oob   <= 1'b0;
    end else begin
      if (w_acc_wr)          r_err_write <= 1'b1;
      if (w_acc_rd && w_oob) r_err_oob   <= 1'b1;
    end
  end

  assign err_write_o = r_err_write;
  assign err_oob_o   = r_err_oob;

`ifdef BSG_BLADERUNNER_ROM_ERR_COUNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err_count <= '0;
    end else if (w_acc_wr || (w_acc_rd && w_oob)) begin
      r_err_count <= sat_inc(r_err_count);
    end
  end

  assign err_count_o = r_err_count;
`else
  assign err_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bsg_bladerunner_rom_banked.sv
// Directed bench for bsg_bladerunner_rom_banked: vector table plus backpressure and reset sequences.
module tb_bsg_bladerunner_rom_banked;

  logic        clk;
  logic        reset_n;
  logic [2:0]  rom_addr;
  logic [63:0] rom_data;
  logic        err_write;
  logic        err_oob;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  bsg_bladerunner_rom_banked_if #(.addr_width_p(8), .data_width_p(32)) ep ();

  bsg_bladerunner_rom_banked #(
    .rom_width_p (64),
    .rom_els_p   (6),
    .data_width_p(32),
    .addr_width_p(8),
    .fifo_els_p  (4)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .ep         (ep),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .err_write_o(err_write),
    .err_oob_o  (err_oob),
    .err_count_o(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ROM: entry k = {B000_000k, A000_000k}; indices past the end return junk.
  always_comb begin
    if (rom_addr < 3'd6) rom_data = {32'hB000_0000 | 32'(rom_addr), 32'hA000_0000 | 32'(rom_addr)};
    else                 rom_data = 64'hDEAD_BEEF_DEAD_BEEF;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic        we;
    logic        oob;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    int k;
    k = (a >> 1) & 7;
    return ((a & 1) != 0) ? (32'hB000_0000 | 32'(k)) : (32'hA000_0000 | 32'(k));
  endfunction

  // Enter and leave aligned at posedge + 1.
  task automatic run_vec(input vec_t v, input logic ef_oob, input logic ef_wr, input logic [15:0] ecnt);
    ep.in_v_i    = 1'b1;
    ep.in_addr_i = v.addr;
    ep.in_mask_i = v.mask;
    ep.in_we_i   = v.we;
    @(negedge clk);
    chk("accept", 32'(ep.in_yumi_o), 32'd1);
    @(posedge clk); #1;
    ep.in_v_i  = 1'b0;
    ep.in_we_i = 1'b0;
    @(negedge clk);
    chk("v_early", 32'(ep.returning_v_o), 32'd0);
    @(negedge clk);
    if (!v.we) begin
      chk("v_lat2", 32'(ep.returning_v_o), 32'd1);
      chk("data", ep.returning_data_o, v.exp);
      ep.returning_yumi_i = 1'b1;
    end else begin
      chk("wr_noresp", 32'(ep.returning_v_o), 32'd0);
    end
    @(posedge clk); #1;
    ep.returning_yumi_i = 1'b0;
    chk("err_oob", 32'(err_oob), 32'(ef_oob));
    chk("err_write", 32'(err_write), 32'(ef_wr));
    chk("err_count", 32'(err_count), 32'(ecnt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_yumi"},  32'(ep.in_yumi_o), 32'd0);
    chk({tag, "_v"},     32'(ep.returning_v_o), 32'd0);
    chk({tag, "_data"},  ep.returning_data_o, 32'd0);
    chk({tag, "_raddr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_ewr"},   32'(err_write), 32'd0);
    chk({tag, "_eoob"},  32'(err_oob), 32'd0);
    chk({tag, "_ecnt"},  32'(err_count), 32'd0);
  endtask

  vec_t vecs[10];
  logic [31:0] bp_exp[6];

  initial begin
    logic       f_oob;
    logic       f_wr;
    logic [15:0] ev;
    int req;
    int popped;
    vec_t v0;

    vecs[0] = '{addr: 8'd5,    mask: 4'hF,    we: 1'b0, oob: 1'b0, exp: 32'hB000_0002};
    vecs[1] = '{addr: 8'd4,    mask: 4'b0101, we: 1'b0, oob: 1'b0, exp: 32'h0000_0002};
    vecs[2] = '{addr: 8'd0,    mask: 4'hF,    we: 1'b0, oob: 1'b0, exp: 32'hA000_0000};
    vecs[3] = '{addr: 8'd11,   mask: 4'hF,    we: 1'b0, oob: 1'b0, exp: 32'hB000_0005};
    vecs[4] = '{addr: 8'd10,   mask: 4'b1000, we: 1'b0, oob: 1'b0, exp: 32'hA000_0000};
    vecs[5] = '{addr: 8'd3,    mask: 4'b1001, we: 1'b0, oob: 1'b0, exp: 32'hB000_0001};
    vecs[6] = '{addr: 8'h85,   mask: 4'hF,    we: 1'b0, oob: 1'b0, exp: 32'hB000_0002};
    vecs[7] = '{addr: 8'd12,   mask: 4'hF,    we: 1'b0, oob: 1'b1, exp: 32'h0000_0000};
    vecs[8] = '{addr: 8'd0,    mask: 4'hF,    we: 1'b1, oob: 1'b0, exp: 32'h0000_0000};
    vecs[9] = '{addr: 8'd15,   mask: 4'hF,    we: 1'b0, oob: 1'b1, exp: 32'h0000_0000};

    for (int i = 0; i < 6; i++) bp_exp[i] = model_word(i);

    ep.in_v_i           = 1'b1;
    ep.in_addr_i        = 8'd0;
    ep.in_mask_i        = 4'hF;
    ep.in_we_i          = 1'b0;
    ep.returning_yumi_i = 1'b0;
    reset_n             = 1'b0;
    #12;
    chk_reset_outputs("rst0");
    @(negedge clk);
    ep.in_v_i = 1'b0;
    reset_n   = 1'b1;
    @(posedge clk); #1;

    f_oob = 1'b0;
    f_wr  = 1'b0;
    ev    = 16'd0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].oob) f_oob = 1'b1;
      if (vecs[i].we)  f_wr  = 1'b1;
      if (vecs[i].oob || vecs[i].we) ev = ev + 16'd1;
`ifdef BSG_BLADERUNNER_ROM_ERR_COUNT_EN
      run_vec(vecs[i], f_oob, f_wr, ev);
`else
      run_vec(vecs[i], f_oob, f_wr, 16'd0);
`endif
    end

    // Backpressure: no pops while six back-to-back reads are offered.
    req    = 0;
    popped = 0;
    ep.in_mask_i = 4'hF;
    ep.in_we_i   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ep.in_v_i    = (req < 6);
      ep.in_addr_i = 8'(req);
      @(negedge clk);
      if (ep.in_yumi_o) req++;
      @(posedge clk); #1;
    end
    ep.in_v_i    = (req < 6);
    ep.in_addr_i = 8'(req);
    @(negedge clk);
    chk("bp_accepted", 32'(req), 32'd4);
    chk("bp_blocked", 32'(ep.in_yumi_o), 32'd0);
    chk("bp_full_v", 32'(ep.returning_v_o), 32'd1);
    ep.in_we_i   = 1'b1;
    ep.in_addr_i = 8'd0;
    #1;
    chk("wr_when_full", 32'(ep.in_yumi_o), 32'd1);
    @(posedge clk); #1;
    ep.in_we_i = 1'b0;

    for (int c = 0; c < 30 && popped < 6; c++) begin
      ep.in_v_i    = (req < 6);
      ep.in_addr_i = 8'(req);
      @(negedge clk);
      ep.returning_yumi_i = ep.returning_v_o;
      #1;
      if (ep.returning_yumi_i) begin
        chk("bp_order", ep.returning_data_o, bp_exp[popped]);
        if (popped == 0) chk("credit_same_cycle", 32'(ep.in_yumi_o), 32'd1);
        popped++;
      end
      if (ep.in_yumi_o) req++;
      @(posedge clk); #1;
      ep.returning_yumi_i = 1'b0;
    end
    ep.in_v_i = 1'b0;
    chk("bp_drained", 32'(popped), 32'd6);
    chk("bp_all_acc", 32'(req), 32'd6);

    // Reset with three responses pending.
    for (int i = 1; i <= 3; i++) begin
      ep.in_v_i    = 1'b1;
      ep.in_addr_i = 8'(i);
      @(posedge clk); #1;
    end
    ep.in_v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pend_v", 32'(ep.returning_v_o), 32'd1);
    chk("pend_flags", 32'({err_oob, err_write}), 32'd3);
    #2;
    reset_n   = 1'b0;
    ep.in_v_i = 1'b1;
    #1;
    chk_reset_outputs("rst1");
    @(negedge clk);
    reset_n   = 1'b1;
    ep.in_v_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_v", 32'(ep.returning_v_o), 32'd0);
    v0 = '{addr: 8'd0, mask: 4'hF, we: 1'b0, oob: 1'b0, exp: 32'hA000_0000};
    run_vec(v0, 1'b0, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_bladerunner_rom_banked.md
# bsg_bladerunner_rom_banked

Read-only configuration ROM server behind a manycore endpoint. It generalises the single-word, fixed-latency, zero-backpressure ROM responder. ROM entries may be wider than the link: each entry is split into link-width chunks. Responses pass through a credit-reserved response FIFO, so the network can stall returns. Writes and out-of-range reads are absorbed and flagged instead of stopping simulation.

## Interface
Parameters:
- rom_width_p, "inv", ROM entry width in bits
- rom_els_p, "inv", number of ROM entries
- data_width_p, 32, link data width
- addr_width_p, "inv", link word-address width
- fifo_els_p, 4, response FIFO depth (>=2)
- chunks_lp, derived, ceil(rom_width_p/data_width_p)
- lg_chunks_lp, derived, BSG_SAFE_CLOG2(chunks_lp)
- lg_rom_els_lp, derived, BSG_SAFE_CLOG2(rom_els_p)

Ports:
- clk_i, in, 1, sole clock
- reset_n_i, in, 1, reset: asynchronous assert, active-low
- in_v_i, in, 1, request valid from endpoint
- in_yumi_o, out, 1, request consumed this cycle
- in_addr_i, in, addr_width_p, word address
- in_mask_i, in, data_width_p/8, byte mask
- in_we_i, in, 1, write request
- rom_addr_o, out, lg_rom_els_lp, entry index to external combinational ROM
- rom_data_i, in, rom_width_p, entry contents for rom_addr_o
- returning_v_o, out, 1, response valid
- returning_data_o, out, data_width_p, masked chunk
- returning_yumi_i, in, 1, response consumed
- err_write_o, out, 1, sticky: write seen
- err_oob_o, out, 1, sticky: entry index >= rom_els_p seen
- err_count_o, out, 16, saturating error count

## Operation
- Address split: chunk = in_addr_i[lg_chunks_lp-1:0]; entry = next lg_rom_els_lp bits. Higher bits are ignored.
- If chunks_lp==1, chunk is 0 and entry starts at bit 0.
- Chunk c covers rom_data_i bits [c*data_width_p +: data_width_p]. Bits above rom_width_p read as 0. Chunk >= chunks_lp reads as 0.
- Acceptance: in_yumi_o = in_v_i & (in_we_i | credits > 0).
  - credits = fifo_els_p - FIFO occupancy - stage-1 reads in flight.
  - Credit is reserved at acceptance and freed when the response is popped.
- Write: consumed in 1 cycle. No response. Sets err_write_o.
- Stage 1 registers: valid, entry, chunk, mask, oob flag. rom_addr_o comes from the stage-1 entry register.
- Stage 2: chunk select and byte mask apply ({8{mask[i]}} per byte). Result is pushed into the FIFO.
- Out-of-range read: returns all-zero data (a response is still sent). Sets err_oob_o.
- FIFO: first-word-fall-through. returning_v_o = FIFO non-empty. Pop on returning_yumi_i.
- returning_yumi_i is legal only while returning_v_o=1.

## Timing
- Reset (reset_n_i=0): all state clears asynchronously and in-flight responses are discarded.
  - Outputs during reset: in_yumi_o=0, returning_v_o=0, returning_data_o=0, rom_addr_o=0, error flags 0, err_count_o 0.
- Read accepted in cycle N → returning_v_o=1 in cycle N+2 if the FIFO was empty.
- Throughput is 1 read/cycle while credits remain.
- FIFO full plus stage 1 occupied → in_yumi_o=0 for reads. A write in the same situation is still consumed.
- Simultaneous pop and push: occupancy unchanged, and the freed credit is usable in the same cycle.
- Response order equals acceptance order.

## Configuration
- BSG_BLADERUNNER_ROM_ERR_COUNT_EN defined:
  - err_count_o increments by 1 per accepted write or out-of-range read.
  - It saturates at 16'hFFFF.
- Not defined: err_count_o is constant 0 and no counter logic is built. The sticky flags remain in both builds.

## Test plan
All scenarios use rom_width_p=64, data_width_p=32, rom_els_p=6, fifo_els_p=4 and ROM entry k = {32'hB000_000k, 32'hA000_000k}.
- Read addr 5 (entry 2, chunk 1), mask 4'hF → 32'hB000_0002 returned 2 cycles after acceptance.
- Read addr 4, mask 4'b0101 → 32'h0000_0002 (masked bytes zeroed).
- Read addr 12 (entry 6, out of range) → data 0, err_oob_o=1, err_count_o=1 with the macro, 0 without.
- returning_yumi_i held 0 while 6 back-to-back reads are driven → exactly 4 accepted, in_yumi_o=0 after. After 4 pops, the remaining 2 return in order.
- Write to addr 0 → consumed in 1 cycle, no returning_v_o, err_write_o=1. Concurrent reads are unaffected.
- reset_n_i pulsed low mid-stream with 3 responses pending → returning_v_o drops immediately and flags clear. After release, a read of addr 0 returns 32'hA000_0000.
